argmax_tree_pipe: RTL and testbench
===================================

Name: argmax_tree_pipe

Overview:
- Parametrised, pipelined arg-max/arg-min reducer over N_IN signed fixed-point lanes. It is the successor to the fixed 12-input classifier comparator.
- Sits at the output of the dense/classifier layer. Takes one packed vector of scores per transaction and returns the winning lane index plus its value.
- Adds over the fixed comparator:
  - any lane count;
  - a max/min mode;
  - deterministic tie-break;
  - valid/ready flow control with back-pressure.

Parameters:
- N_IN, 12, number of input lanes; legal range 2..256.
- DATA_LEN, 18, width of one signed lane (two's complement); defaults to the shared data-length constant.
- IDX_W, $clog2(N_IN), width of the index output; derived, not overridden.
- LEVELS, $clog2(N_IN), number of register stages in the tree; derived.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input vector present.
- in_ready  out  1  block accepts input this cycle.
- in_mode  in  1  0 = arg-max, 1 = arg-min; sampled with the data.
- in_data  in  N_IN*DATA_LEN  packed signed lanes; lane i = bits [i*DATA_LEN +: DATA_LEN]; lane 0 in the LSBs.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- out_idx  out  IDX_W  winning lane number.
- out_val  out  DATA_LEN  winning lane value (signed).

Behaviour:
- Reset: on a rising clk edge with rst=1, all stage valid bits clear; out_valid=0, out_idx=0, out_val=0. The stage data registers are also cleared to 0.
- Flow control:
  - One global advance enable, adv = !out_valid || out_ready.
  - in_ready = adv. in_ready is combinational from out_valid/out_ready only, never from in_valid.
  - Accept occurs when in_valid && in_ready. When adv=0, every stage (valid bits and data) holds.
- Pipeline:
  - Level k (k=1..LEVELS) compares pairs of level k-1 candidates and registers the survivor on adv.
  - Level 0 is the unregistered input.
  - Latency: exactly LEVELS cycles from accept to out_valid with no back-pressure (N_IN=12 gives 4 cycles).
  - Throughput: 1 vector per cycle.
- Candidate format:
  - {present, idx, val}. Input lanes are present=1 with idx=i.
  - Pad lanes up to 2^LEVELS are present=0. A non-present candidate never wins against a present one.
  - Two non-present candidates produce a non-present result.
- Compare rule for pair (a = lower-index side, b = higher-index side):
  - max mode: b wins iff b.val > a.val (signed).
  - min mode: b wins iff b.val < a.val (signed).
  - Ties: a wins, so the lowest lane index wins overall.
- Mode: in_mode travels through the pipeline alongside its vector. Back-to-back vectors with different modes are each evaluated in their own mode.
- Bubbles: a stage whose valid bit is 0 still advances its data on adv. Its contents are don't-care and must not raise out_valid.
- Output hold: while out_valid=1 && out_ready=0, out_idx and out_val are stable and no input is accepted.
- Reset mid-operation: all in-flight vectors are discarded with no partial output; the first accept after rst deasserts behaves as from power-up.
- Width rules:
  - Comparisons are full-width signed with no saturation.
  - out_val is the winning lane value unchanged.
  - out_idx is always < N_IN.

Decomposition:
- Shared package/include:
  - DATA_LEN default (18);
  - MODE_MAX=0, MODE_MIN=1 constants;
  - clog2 helper, if not already present.
- Sub-module cmp_select_node: combinational compare-select of two {present, idx, val} candidates with mode input, implementing the tie and present rules. The top instantiates it in a generate tree and owns all registers and handshake logic.

Test Plan:
- Ascending lanes 0..11 (N_IN=12), mode=0, out_ready=1 → after 4 cycles out_valid=1, out_idx=11, out_val=11. Same data with mode=1 → out_idx=0, out_val=0.
- Signed lanes {-5, 3, -131072, 3, 131071, 7, ...rest 0}, mode=0 → out_idx=4, out_val=131071. mode=1 → out_idx=2, out_val=-131072.
- All lanes=5, both modes → out_idx=0, out_val=5 (tie rule). Lanes 3 and 9 =20, others 0, mode=0 → out_idx=3.
- Stream 8 vectors back-to-back, holding out_ready=0 for 3 cycles mid-stream → in_ready drops the same cycle, outputs hold stable, all 8 results arrive in order with none lost or duplicated.
- N_IN=5 (LEVELS=3), all lanes=-1, mode=0 → out_idx=0, out_val=-1; pad lanes never selected. N_IN=2 → latency 1 cycle.
- Assert rst for 1 cycle with 3 vectors in flight → no out_valid for those vectors; out_idx=0, out_val=0, out_valid=0 the cycle after reset; the next vector completes after LEVELS cycles.

Source files
------------

// File: rtl/argmax_tree_pipe_pkg.sv
// Shared constants for the arg-max/arg-min reduction tree.
//   DATA_LEN_DEFAULT : default signed lane width shared with the classifier datapath
//   MODE_MAX/MODE_MIN: encoding of the per-vector mode bit
//   clog2            : ceiling log2 for elaboration-time sizing
package argmax_tree_pipe_pkg;

  localparam int   DATA_LEN_DEFAULT = 18;
  localparam logic MODE_MAX         = 1'b0;
  localparam logic MODE_MIN         = 1'b1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/argmax_tree_pipe_cmp_select_node.sv
// Combinational compare-select of two tree candidates {present, idx, val}.
//   mode         : MODE_MAX picks the larger value, MODE_MIN the smaller
//   a_*          : candidate from the lower lane-index side
//   b_*          : candidate from the higher lane-index side
//   y_*          : surviving candidate
// b only displaces a on a strict win, so equal values keep the lower index.
// A missing candidate never beats a present one; two missing ones stay missing.
module cmp_select_node
  import argmax_tree_pipe_pkg::*;
#(
  parameter int IDX_W    = 4,
  parameter int DATA_LEN = DATA_LEN_DEFAULT
) (
  input  logic                       mode,
  input  logic                       a_present,
  input  logic [IDX_W-1:0]           a_idx,
  input  logic signed [DATA_LEN-1:0] a_val,
  input  logic                       b_present,
  input  logic [IDX_W-1:0]           b_idx,
  input  logic signed [DATA_LEN-1:0] b_val,
  output logic                       y_present,
  output logic [IDX_W-1:0]           y_idx,
  output logic signed [DATA_LEN-1:0] y_val
);

  logic b_better;
  logic b_wins;

  always_comb begin
    b_better  = (mode == MODE_MIN) ? (b_val < a_val) : (b_val > a_val);
    b_wins    = b_present && (!a_present || b_better);
    y_present = a_present | b_present;
    y_idx     = b_wins ? b_idx : a_idx;
    y_val     = b_wins ? b_val : a_val;
  end

endmodule

// File: rtl/argmax_tree_pipe.sv
// Pipelined arg-max / arg-min reducer over N_IN signed lanes.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : input handshake; in_ready depends only on the output side
//   in_mode             : 0 = arg-max, 1 = arg-min, carried along with its vector
//   in_data             : packed lanes, lane i at [i*DATA_LEN +: DATA_LEN]
//   out_valid/out_ready : output handshake
//   out_idx, out_val    : winning lane index and its unmodified value
// The tree is stored heap-style: node 1 is the root, node n has children 2n
// (lower lanes) and 2n+1, and leaves NPAD..2*NPAD-1 are the unregistered lanes.
// Every internal node is a register, so a level-k node holds the vector that
// entered k cycles ago. One advance enable moves the whole pipe or freezes it.
module argmax_tree_pipe
  import argmax_tree_pipe_pkg::*;
#(
  parameter  int N_IN     = 12,
  parameter  int DATA_LEN = DATA_LEN_DEFAULT,
  localparam int IDX_W    = clog2(N_IN),
  localparam int LEVELS   = clog2(N_IN)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_mode,
  input  logic [N_IN*DATA_LEN-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [IDX_W-1:0]         out_idx,
  output logic [DATA_LEN-1:0]      out_val
);

  localparam int NPAD = 1 << LEVELS;

  typedef struct packed {
    logic                       present;
    logic [IDX_W-1:0]           idx;
    logic signed [DATA_LEN-1:0] val;
  } cand_t;

  cand_t             leaf   [NPAD];
  cand_t             node_d [1:NPAD-1];
  cand_t             node_q [1:NPAD-1];
  logic [LEVELS-1:0] vld_q;     // bit k-1 : vector present at level k
  logic [LEVELS-1:0] mode_lvl;  // bit k   : mode of the vector at level k
  logic              adv;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Lanes beyond N_IN become absent candidates so they can never win.
  for (genvar i = 0; i < NPAD; i++) begin : g_leaf
    if (i < N_IN) begin : g_lane
      assign leaf[i] = {1'b1, IDX_W'(i), in_data[i*DATA_LEN +: DATA_LEN]};
    end else begin : g_pad
      assign leaf[i] = '0;
    end
  end

  for (genvar k = 1; k <= LEVELS; k++) begin : g_level
    for (genvar j = 0; j < (NPAD >> k); j++) begin : g_node
      localparam int N = (NPAD >> k) + j;
      cand_t                      ca;
      cand_t                      cb;
      logic                       y_present;
      logic [IDX_W-1:0]           y_idx;
      logic signed [DATA_LEN-1:0] y_val;

      if (k == 1) begin : g_from_leaf
        assign ca = leaf[2*j];
        assign cb = leaf[2*j+1];
      end else begin : g_from_node
        assign ca = node_q[2*N];
        assign cb = node_q[2*N+1];
      end

      cmp_select_node #(
        .IDX_W    (IDX_W),
        .DATA_LEN (DATA_LEN)
      ) u_node (
        .mode      (mode_lvl[k-1]),
        .a_present (ca.present),
        .a_idx     (ca.idx),
        .a_val     (ca.val),
        .b_present (cb.present),
        .b_idx     (cb.idx),
        .b_val     (cb.val),
        .y_present (y_present),
        .y_idx     (y_idx),
        .y_val     (y_val)
      );

      assign node_d[N] = {y_present, y_idx, y_val};
    end
  end

  // The root level never needs its mode, so only LEVELS-1 mode bits are stored.
  if (LEVELS == 1) begin : g_mode_single
    assign mode_lvl = in_mode;
  end else begin : g_mode_pipe
    logic [LEVELS-2:0] mode_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        mode_q <= '0;
      end else if (adv) begin
        mode_q[0] <= in_mode;
        for (int i = 1; i < LEVELS - 1; i++) mode_q[i] <= mode_q[i-1];
      end
    end

    assign mode_lvl = {mode_q, in_mode};
  end

  // Bubbles still shift their (don't-care) data; only vld_q qualifies it.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int n = 1; n < NPAD; n++) node_q[n] <= '0;
    end else if (adv) begin
      vld_q[0] <= in_valid;
      for (int i = 1; i < LEVELS; i++) vld_q[i] <= vld_q[i-1];
      for (int n = 1; n < NPAD; n++) node_q[n] <= node_d[n];
    end
  end

  assign out_valid = vld_q[LEVELS-1] & node_q[1].present;
  assign out_idx   = node_q[1].idx;
  assign out_val   = node_q[1].val;

endmodule

// File: tb/tb_argmax_tree_pipe.sv
module tb_argmax_tree_pipe;

  localparam int DL = 18;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic            v12, r12, m12, ov12, or12;
  logic [12*DL-1:0] d12;
  logic [3:0]      idx12;
  logic [DL-1:0]   val12;

  logic            v5, r5, m5, ov5, or5;
  logic [5*DL-1:0] d5;
  logic [2:0]      idx5;
  logic [DL-1:0]   val5;

  logic            v2, r2, m2, ov2, or2;
  logic [2*DL-1:0] d2;
  logic [0:0]      idx2;
  logic [DL-1:0]   val2;

  argmax_tree_pipe #(.N_IN(12), .DATA_LEN(DL)) dut12 (
    .clk(clk), .rst(rst), .in_valid(v12), .in_ready(r12), .in_mode(m12),
    .in_data(d12), .out_valid(ov12), .out_ready(or12), .out_idx(idx12), .out_val(val12));

  argmax_tree_pipe #(.N_IN(5), .DATA_LEN(DL)) dut5 (
    .clk(clk), .rst(rst), .in_valid(v5), .in_ready(r5), .in_mode(m5),
    .in_data(d5), .out_valid(ov5), .out_ready(or5), .out_idx(idx5), .out_val(val5));

  argmax_tree_pipe #(.N_IN(2), .DATA_LEN(DL)) dut2 (
    .clk(clk), .rst(rst), .in_valid(v2), .in_ready(r2), .in_mode(m2),
    .in_data(d2), .out_valid(ov2), .out_ready(or2), .out_idx(idx2), .out_val(val2));

  typedef struct {
    int idx;
    int val;
    int lat;   // expected cycle count when the result first shows, -1 = unchecked
  } exp_t;

  exp_t q12[$];
  exp_t q5[$];
  exp_t q2[$];
  exp_t e12, e5, e2;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int lanes[12];

  logic held_v;
  int   held_idx, held_val;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [12*DL-1:0] pack_lanes(input int n);
    logic [12*DL-1:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[i*DL +: DL] = DL'(lanes[i]);
    return r;
  endfunction

  task automatic set_all(input int v);
    for (int i = 0; i < 12; i++) lanes[i] = v;
  endtask

  // Presents lanes[] to one DUT, waits for acceptance and queues the expectation.
  task automatic send(input int dut, input logic m, input int eidx, input int evl,
                      input bit lat_chk, input bit push);
    logic [12*DL-1:0] p;
    bit   ok;
    exp_t e;
    p = pack_lanes(dut);
    case (dut)
      12:      begin d12 = p;            m12 = m; v12 = 1'b1; end
      5:       begin d5  = p[5*DL-1:0];  m5  = m; v5  = 1'b1; end
      default: begin d2  = p[2*DL-1:0];  m2  = m; v2  = 1'b1; end
    endcase
    ok = 1'b0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if ((dut == 12 && r12) || (dut == 5 && r5) || (dut == 2 && r2)) begin
        ok = 1'b1;
        break;
      end
    end
    e = '{eidx, evl, -1};
    if (lat_chk) e.lat = cyc + ((dut == 12) ? 4 : (dut == 5) ? 3 : 1);
    if (!ok) check("accept_timeout", 0, 1);
    else if (push) begin
      case (dut)
        12:      q12.push_back(e);
        5:       q5.push_back(e);
        default: q2.push_back(e);
      endcase
    end
    @(posedge clk);
    #1;
    v12 = 1'b0; v5 = 1'b0; v2 = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      held_v = 1'b0;
    end else begin
      if (ov12 && held_v) begin
        check("hold_idx12", int'(idx12), held_idx);
        check("hold_val12", int'($signed(val12)), held_val);
      end
      if (ov12 && !or12) begin
        check("in_ready_stall12", int'(r12), 0);
        held_v   = 1'b1;
        held_idx = int'(idx12);
        held_val = int'($signed(val12));
      end else begin
        held_v = 1'b0;
      end
      if (ov12 && or12) begin
        check("in_ready_free12", int'(r12), 1);
        if (q12.size() == 0) check("unexpected_out12", 1, 0);
        else begin
          e12 = q12.pop_front();
          check("idx12", int'(idx12), e12.idx);
          check("val12", int'($signed(val12)), e12.val);
          if (e12.lat >= 0) check("latency12", cyc, e12.lat);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && ov5) begin
      if (q5.size() == 0) check("unexpected_out5", 1, 0);
      else begin
        e5 = q5.pop_front();
        check("idx5", int'(idx5), e5.idx);
        check("val5", int'($signed(val5)), e5.val);
        if (e5.lat >= 0) check("latency5", cyc, e5.lat);
      end
    end
    if (!rst && ov2) begin
      if (q2.size() == 0) check("unexpected_out2", 1, 0);
      else begin
        e2 = q2.pop_front();
        check("idx2", int'(idx2), e2.idx);
        check("val2", int'($signed(val2)), e2.val);
        if (e2.lat >= 0) check("latency2", cyc, e2.lat);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    v12 = 1'b0; m12 = 1'b0; d12 = '0; or12 = 1'b1;
    v5  = 1'b0; m5  = 1'b0; d5  = '0; or5  = 1'b1;
    v2  = 1'b0; m2  = 1'b0; d2  = '0; or2  = 1'b1;
    held_v = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid12", int'(ov12), 0);
    check("rst_idx12", int'(idx12), 0);
    check("rst_val12", int'($signed(val12)), 0);
    check("rst_valid5", int'(ov5), 0);
    check("rst_valid2", int'(ov2), 0);
    rst = 1'b0;

    // ascending lanes, both modes
    for (int i = 0; i < 12; i++) lanes[i] = i;
    send(12, 1'b0, 11, 11, 1, 1);
    send(12, 1'b1, 0, 0, 1, 1);

    // signed extremes
    lanes = '{-5, 3, -131072, 3, 131071, 7, 0, 0, 0, 0, 0, 0};
    send(12, 1'b0, 4, 131071, 1, 1);
    send(12, 1'b1, 2, -131072, 1, 1);

    // ties resolve to the lowest lane
    set_all(5);
    send(12, 1'b0, 0, 5, 1, 1);
    send(12, 1'b1, 0, 5, 1, 1);
    set_all(0); lanes[3] = 20; lanes[9] = 20;
    send(12, 1'b0, 3, 20, 1, 1);
    set_all(0); lanes[3] = -20; lanes[9] = -20;
    send(12, 1'b1, 3, -20, 1, 1);

    // 8-vector stream with a 3-cycle output stall in the middle
    fork
      begin
        for (int j = 0; j < 8; j++) begin
          set_all(0);
          lanes[(j*5) % 12] = (j % 2 == 1) ? -(100 + j) : (100 + j);
          send(12, logic'(j % 2), (j*5) % 12, (j % 2 == 1) ? -(100 + j) : (100 + j), 0, 1);
        end
      end
      begin
        repeat (5) @(posedge clk);
        #1 or12 = 1'b0;
        repeat (3) @(posedge clk);
        #1 or12 = 1'b1;
      end
    join

    for (int t = 0; t < 100 && q12.size() != 0; t++) @(negedge clk);
    check("stream_drained12", q12.size(), 0);
    @(posedge clk);
    #1;

    // reset with three vectors in flight
    for (int i = 0; i < 12; i++) lanes[i] = i;
    send(12, 1'b0, 11, 11, 0, 0);
    send(12, 1'b0, 11, 11, 0, 0);
    send(12, 1'b0, 11, 11, 0, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_valid12", int'(ov12), 0);
    check("midrst_idx12", int'(idx12), 0);
    check("midrst_val12", int'($signed(val12)), 0);
    send(12, 1'b1, 0, 0, 1, 1);

    // N_IN=5: padded tree, pad lanes must never win
    set_all(-1);
    send(5, 1'b0, 0, -1, 1, 1);
    send(5, 1'b1, 0, -1, 1, 1);
    lanes[0] = 1; lanes[1] = 2; lanes[2] = 3; lanes[3] = 4; lanes[4] = 9;
    send(5, 1'b0, 4, 9, 1, 1);
    lanes[0] = -7; lanes[1] = -3; lanes[2] = 0; lanes[3] = -7; lanes[4] = 6;
    send(5, 1'b1, 0, -7, 1, 1);

    // N_IN=2: single-level tree
    lanes[0] = 7; lanes[1] = -8;
    send(2, 1'b0, 0, 7, 1, 1);
    send(2, 1'b1, 1, -8, 1, 1);
    lanes[0] = 4; lanes[1] = 4;
    send(2, 1'b1, 0, 4, 1, 1);

    for (int t = 0; t < 200 && (q12.size() + q5.size() + q2.size()) != 0; t++)
      @(negedge clk);
    repeat (6) @(negedge clk);
    check("left_in_q12", q12.size(), 0);
    check("left_in_q5", q5.size(), 0);
    check("left_in_q2", q2.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
